atm_txn_arbiter: RTL and testbench
==================================

# atm_txn_arbiter

- Round-robin controller that shares one single-port balance memory between N_TERM ATM terminals.
- Accepts one request per terminal and grants exactly one transaction at a time.
- Sequences each transaction as read-modify-write: balance inquiry, withdraw or deposit.
- Returns the resulting balance and a status code to the granted terminal.
- Sits between the per-terminal ATM front ends and the shared balance store.

## Interface
Parameters:
- N_TERM, 4, number of requesting terminals (2..8)
- N_ACCT, 10, valid account indices 0..N_ACCT-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_TERM  per-terminal request, level, held until that terminal's done
- op  in  2*N_TERM  per-terminal op; 00 nop, 01 balance, 10 withdraw, 11 deposit
- acc  in  4*N_TERM  per-terminal account index
- amt  in  16*N_TERM  per-terminal amount, unsigned
- done  out  N_TERM  one-hot, one-cycle completion pulse
- rsp_balance  out  16  result balance, valid only while done != 0
- rsp_status  out  2  00 OK, 01 insufficient funds, 10 bad account/op, 11 deposit overflow
- busy  out  1  high in any state other than IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable, only with mem_en
- mem_addr  out  4  account index
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid the cycle after mem_en with mem_we=0
- txn_count  out  16  completed-transaction counter (see Configuration)

## Operation
- FSM states: IDLE, READ, EXEC, RESP.
- IDLE:
  - If any req is high, grant the first requester found searching from last_gnt+1 upward, with wrap-around.
  - Latch the winner's index, op, acc and amt; update last_gnt.
  - Go to RESP with status 10 if op==00 or acc>=N_ACCT. Otherwise go to READ.
- READ: mem_en=1, mem_we=0, mem_addr=latched acc. Go to EXEC.
- EXEC uses mem_rdata as the current balance, then goes to RESP:
  - Balance: no write; result = rdata; status 00.
  - Withdraw, amt<=rdata: write rdata-amt; status 00. A zero-amount withdraw still writes.
  - Withdraw, amt>rdata: no write; result = rdata; status 01.
  - Deposit: compute the 17-bit sum. If bit 16 is set: no write; result = rdata; status 11. Otherwise write the sum[15:0]; status 00.
  - A write drives mem_en=mem_we=1, mem_addr=acc, mem_wdata=new balance.
- RESP:
  - done[granted]=1; rsp_balance = result balance (0 for status 10); rsp_status valid.
  - Go to IDLE.
- rsp_balance and rsp_status are 0 whenever no done bit is set.
- The granted terminal must drop req at the clock edge that samples done. A req still high in IDLE is treated as a new request.
- Requests arriving while busy wait. Inputs of non-granted terminals are ignored.
- Outputs are decoded from registered state and latched operands only, so there is no combinational path from req/op/acc/amt to any output.

## Timing
- Normal transaction: request sampled in IDLE (cycle 0); READ in cycle 1; EXEC/write in cycle 2; done in cycle 3. Next grant can occur no earlier than cycle 4.
- Bad account or op: done in cycle 1; no memory access.
- Throughput: one transaction per 4 cycles with continuous requests.
- Reset values:
  - State IDLE; last_gnt = N_TERM-1, so terminal 0 wins first.
  - done, rsp_balance, rsp_status, busy, mem_* and txn_count are all 0.
- Reset mid-transaction:
  - The transaction is abandoned at the edge and no done is issued.
  - If rst is high during the EXEC cycle, that cycle's write is still presented; reset takes effect at the following edge.
- Simultaneous requests are resolved purely by the round-robin pointer. No terminal waits more than N_TERM-1 transactions.

## Configuration
- ATM_ARB_AUDIT_EN defined: txn_count increments by 1 on every done pulse, whatever the status. It wraps 0xFFFF to 0x0000 and is cleared by rst.
- ATM_ARB_AUDIT_EN undefined: txn_count is tied to 0 and no counter logic exists.

## Test plan
- Single terminal, memory account 3 = 500: withdraw 200 on acc 3 -> write 300 in cycle 2, done in cycle 3, rsp_balance 300, status 00.
- Withdraw 600 from balance 500 -> no mem_we, rsp_balance 500, status 01. Deposit 0xFFF0 onto 500 -> no write, status 11.
- acc=12 or op=00 -> done in cycle 1, status 10, rsp_balance 0, mem_en never asserted.
- All 4 terminals request in the same cycle after reset -> grants in order 0,1,2,3 with done pulses 4 cycles apart. Terminal 0 re-requesting is served after 3.
- Assert rst during READ -> no done, no write; outputs 0 after the edge. The next request starts cleanly at terminal 0.
- With ATM_ARB_AUDIT_EN, 5 transactions of mixed status -> txn_count=5. Without it, txn_count stays 0.

Source files
------------

// File: rtl/atm_txn_arbiter.sv
// Round-robin read-modify-write arbiter sharing one balance memory among ATM terminals.
// Optional ATM_ARB_AUDIT_EN enables the completed-transaction counter on txn_count.
module atm_txn_arbiter #(
    parameter int N_TERM = 4,
    parameter int N_ACCT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_TERM-1:0]     req,
    input  logic [2*N_TERM-1:0]   op,
    input  logic [4*N_TERM-1:0]   acc,
    input  logic [16*N_TERM-1:0]  amt,
    output logic [N_TERM-1:0]     done,
    output logic [15:0]           rsp_balance,
    output logic [1:0]            rsp_status,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic [15:0]           txn_count
);
    localparam int IW = (N_TERM > 1) ? $clog2(N_TERM) : 1;

    typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  last_gnt, gnt_q, sel, cand;
    logic           found;
    logic [1:0]     sel_op, op_q, sts_q, sts_nx;
    logic [3:0]     sel_acc, acc_q;
    logic [15:0]    sel_amt, amt_q, res_q, res_nx;
    logic           sel_bad, wr;
    logic [16:0]    sum;

    // First requester after last_gnt, wrapping around
    always_comb begin
        found = 1'b0;
        sel   = last_gnt;
        cand  = '0;
        for (int i = 1; i <= N_TERM; i++) begin
            cand = IW'((int'(last_gnt) + i) % N_TERM);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign sel_op  = op[sel*2 +: 2];
    assign sel_acc = acc[sel*4 +: 4];
    assign sel_amt = amt[sel*16 +: 16];
    assign sel_bad = (sel_op == 2'b00) || (int'(sel_acc) >= N_ACCT);
    assign sum     = {1'b0, mem_rdata} + {1'b0, amt_q};

    always_comb begin
        res_nx = mem_rdata;
        sts_nx = 2'b00;
        wr     = 1'b0;
        unique case (op_q)
            2'b10: begin
                if (amt_q <= mem_rdata) begin
                    wr     = 1'b1;
                    res_nx = mem_rdata - amt_q;
                end else begin
                    sts_nx = 2'b01;
                end
            end
            2'b11: begin
                if (sum[16]) begin
                    sts_nx = 2'b11;
                end else begin
                    wr     = 1'b1;
                    res_nx = sum[15:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = sel_bad ? RESP : READ;
            READ:    state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= IW'(N_TERM - 1);
            gnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            amt_q    <= '0;
            res_q    <= '0;
            sts_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                gnt_q    <= sel;
                last_gnt <= sel;
                op_q     <= sel_op;
                acc_q    <= sel_acc;
                amt_q    <= sel_amt;
                res_q    <= '0;
                sts_q    <= sel_bad ? 2'b10 : 2'b00;
            end else if (state == EXEC) begin
                res_q <= res_nx;
                sts_q <= sts_nx;
            end
        end
    end

    // Outputs depend only on registered state, latched operands and mem_rdata
    always_comb begin
        busy        = (state != IDLE);
        mem_en      = (state == READ) || (state == EXEC && wr);
        mem_we      = (state == EXEC) && wr;
        mem_addr    = mem_en ? acc_q : 4'd0;
        mem_wdata   = mem_we ? res_nx : 16'd0;
        done        = (state == RESP) ? (N_TERM'(1) << gnt_q) : '0;
        rsp_balance = (state == RESP) ? res_q : 16'd0;
        rsp_status  = (state == RESP) ? sts_q : 2'b00;
    end

`ifdef ATM_ARB_AUDIT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state == RESP) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign txn_count = cnt_q;
`else
    assign txn_count = 16'd0;
`endif
endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Bench for atm_txn_arbiter: vector table, hand sequences and a random run
// against a transaction-level balance model.
module tb_atm_txn_arbiter;
    localparam int NT = 4;
    localparam int NA = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    req = '0;
    logic [7:0]    op = '0;
    logic [15:0]   acc = '0;
    logic [63:0]   amt = '0;
    logic [3:0]    done;
    logic [15:0]   rsp_balance;
    logic [1:0]    rsp_status;
    logic          busy, mem_en, mem_we;
    logic [3:0]    mem_addr;
    logic [15:0]   mem_wdata, mem_rdata, txn_count;

    logic [15:0]   mem [16];
    logic          pre_en = 1'b0;
    logic [3:0]    pre_addr = '0;
    logic [15:0]   pre_data = '0;
    int            ndone = 0;
    int            passed = 0;
    int            total = 0;

    atm_txn_arbiter #(.N_TERM(NT), .N_ACCT(NA)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .acc(acc), .amt(amt),
        .done(done), .rsp_balance(rsp_balance), .rsp_status(rsp_status),
        .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (rst) ndone <= 0;
        else if (done != 0) ndone <= ndone + 1;
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [3:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_rsp"}, {rsp_balance, rsp_status}, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_mem"}, {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < NT; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef ATM_ARB_AUDIT_EN
        return 16'(ndone);
`else
        return 16'd0;
`endif
    endfunction

    task automatic run_txn(input int t, input logic [1:0] o, input logic [3:0] a,
                           input logic [15:0] m, output int lat, output logic [3:0] dv,
                           output logic [15:0] bal, output logic [1:0] st,
                           output bit wr, output logic [15:0] wd, output bit en);
        op[2*t +: 2] = o; acc[4*t +: 4] = a; amt[16*t +: 16] = m; req[t] = 1'b1;
        lat = -1; dv = 0; bal = 0; st = 0; wr = 0; wd = 0; en = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (mem_en) en = 1;
            if (mem_we) begin wr = 1; wd = mem_wdata; end
            if (done != 0) begin
                lat = c; dv = done; bal = rsp_balance; st = rsp_status;
                break;
            end
        end
        req[t] = 1'b0;
        tick();
    endtask

    typedef struct {
        int t; logic [1:0] o; logic [3:0] a; logic [15:0] m; logic [15:0] pre;
        logic [15:0] eb; logic [1:0] es; int el; bit ew;
    } vec_t;

    vec_t        vt[11];
    logic [15:0] ref_bal[16];

    initial begin
        int lat, nd, lastc, w, done_cyc, gw, n;
        logic [3:0] dv, prev_req, expd;
        logic [15:0] bal, wd, eb, cur;
        logic [1:0] st, es, o;
        logic [3:0] a;
        logic [15:0] m;
        logic [16:0] s;
        bit wr, en, rereq, dropped;
        int order[5];

        vt[0]  = '{0, 2'b10, 4'd3,  16'd200,   16'd500,   16'd300,   2'b00, 3, 1'b1};
        vt[1]  = '{0, 2'b10, 4'd3,  16'd600,   16'd500,   16'd500,   2'b01, 3, 1'b0};
        vt[2]  = '{1, 2'b11, 4'd3,  16'hFFF0,  16'd500,   16'd500,   2'b11, 3, 1'b0};
        vt[3]  = '{2, 2'b00, 4'd3,  16'd5,     16'd500,   16'd0,     2'b10, 1, 1'b0};
        vt[4]  = '{3, 2'b10, 4'd12, 16'd5,     16'd0,     16'd0,     2'b10, 1, 1'b0};
        vt[5]  = '{1, 2'b01, 4'd7,  16'd0,     16'd1234,  16'd1234,  2'b00, 3, 1'b0};
        vt[6]  = '{2, 2'b10, 4'd5,  16'd0,     16'd77,    16'd77,    2'b00, 3, 1'b1};
        vt[7]  = '{3, 2'b11, 4'd9,  16'd100,   16'd65435, 16'd65535, 2'b00, 3, 1'b1};
        vt[8]  = '{0, 2'b11, 4'd9,  16'd101,   16'd65435, 16'd65435, 2'b11, 3, 1'b0};
        vt[9]  = '{1, 2'b10, 4'd4,  16'd50,    16'd50,    16'd0,     2'b00, 3, 1'b1};
        vt[10] = '{2, 2'b01, 4'd10, 16'd0,     16'd0,     16'd0,     2'b10, 1, 1'b0};

        do_reset();
        chk_quiet("reset");
        chk("reset_cnt", txn_count, 0);

        foreach (vt[i]) begin
            preset(vt[i].a, vt[i].pre);
            run_txn(vt[i].t, vt[i].o, vt[i].a, vt[i].m, lat, dv, bal, st, wr, wd, en);
            chk($sformatf("v%0d_lat", i), lat, vt[i].el);
            chk($sformatf("v%0d_done", i), dv, 4'b1 << vt[i].t);
            chk($sformatf("v%0d_bal", i), bal, vt[i].eb);
            chk($sformatf("v%0d_sts", i), st, vt[i].es);
            chk($sformatf("v%0d_we", i), wr, vt[i].ew);
            chk($sformatf("v%0d_en", i), en, vt[i].el == 3);
            if (vt[i].ew) begin
                chk($sformatf("v%0d_wdata", i), wd, vt[i].eb);
                chk($sformatf("v%0d_mem", i), mem[vt[i].a], vt[i].eb);
            end
        end
        chk("table_cnt", txn_count, exp_cnt());

        // All four request together, then terminal 0 comes back
        do_reset();
        for (int t = 0; t < NT; t++) begin
            op[2*t +: 2] = 2'b01; acc[4*t +: 4] = 4'(t); req[t] = 1'b1;
        end
        order = '{0, 1, 2, 3, 0};
        nd = 0; lastc = 0; rereq = 0;
        for (int c = 1; c <= 40 && nd < 5; c++) begin
            tick();
            if (rereq) begin req[0] = 1'b1; rereq = 0; end
            if (done != 0) begin
                w = idx_of(done);
                chk($sformatf("rr%0d_who", nd), w, order[nd]);
                if (nd > 0) chk($sformatf("rr%0d_gap", nd), c - lastc, 4);
                if (w >= 0) req[w] = 1'b0;
                if (nd == 0) rereq = 1;
                lastc = c;
                nd++;
            end
        end
        chk("rr_count", nd, 5);
        req = '0;
        tick();
        chk("rr_cnt", txn_count, exp_cnt());

        // Reset during READ abandons the transaction
        preset(4'd3, 16'd500);
        op[1:0] = 2'b10; acc[3:0] = 4'd3; amt[15:0] = 16'd1; req[0] = 1'b1;
        tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1; req = '0;
        tick();
        chk_quiet("mid_rst");
        rst = 1'b0;
        tick();
        chk("mid_mem", mem[3], 500);
        op[1:0] = 2'b01; req[0] = 1'b1;
        op[3:2] = 2'b01; acc[7:4] = 4'd4; req[1] = 1'b1;
        nd = 0;
        for (int c = 1; c <= 20 && nd < 2; c++) begin
            tick();
            if (done != 0) begin
                w = idx_of(done);
                if (nd == 0) begin
                    chk("post_who", w, 0);
                    chk("post_bal", rsp_balance, 500);
                end else begin
                    chk("post_who2", w, 1);
                end
                if (w >= 0) req[w] = 1'b0;
                nd++;
            end
        end
        chk("post_count", nd, 2);
        req = '0;
        tick();

        // Random traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cur = ($urandom_range(0, 3) == 0) ? 16'(65535 - $urandom_range(0, 200))
                                              : 16'($urandom_range(0, 1000));
            ref_bal[i] = cur;
            preset(4'(i), cur);
        end
        gw = NT - 1; w = 0; done_cyc = -10; prev_req = '0; eb = 0; es = 0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            tick();
            if (cyc - 1 > done_cyc && prev_req != 0) begin
                for (int i = 1; i <= NT; i++) begin
                    n = (gw + i) % NT;
                    if (prev_req[n]) begin w = n; break; end
                end
                gw = w;
                o = op[2*w +: 2]; a = acc[4*w +: 4]; m = amt[16*w +: 16];
                es = 2'b00;
                if (o == 2'b00 || int'(a) >= NA) begin
                    eb = 0; es = 2'b10; done_cyc = cyc;
                end else begin
                    cur = ref_bal[a]; eb = cur; done_cyc = cyc + 2;
                    if (o == 2'b10) begin
                        if (m <= cur) begin eb = cur - m; ref_bal[a] = eb; end
                        else es = 2'b01;
                    end else if (o == 2'b11) begin
                        s = 17'(cur) + 17'(m);
                        if (s > 17'd65535) es = 2'b11;
                        else begin eb = s[15:0]; ref_bal[a] = eb; end
                    end
                end
            end
            expd = (cyc == done_cyc) ? (4'b1 << w) : 4'b0;
            chk("rnd_done", done, expd);
            chk("rnd_rsp", {rsp_balance, rsp_status}, (cyc == done_cyc) ? {eb, es} : 18'd0);
            dropped = 0;
            if (cyc == done_cyc) begin req[w] = 1'b0; dropped = 1; end
            if (cyc <= 540) begin
                for (int t = 0; t < NT; t++) begin
                    if (!req[t] && !(dropped && t == w) && $urandom_range(0, 3) == 0) begin
                        op[2*t +: 2] = 2'($urandom_range(0, 3));
                        acc[4*t +: 4] = 4'($urandom_range(0, 11));
                        amt[16*t +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                                      : 16'($urandom_range(0, 300));
                        req[t] = 1'b1;
                    end
                end
            end
            prev_req = req;
        end
        chk("rnd_drained", {req, busy}, 0);
        for (int i = 0; i < NA; i++) chk($sformatf("rnd_mem%0d", i), mem[i], ref_bal[i]);
        chk("rnd_cnt", txn_count, exp_cnt());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
